// File: rtl/decode_issue_stage_pkg.sv
// Shared command encodings, opcodes and build options for decode_issue_stage.
// Optional macro WB_BYPASS_EN enables same-cycle writeback bypass.
`ifndef FUNC_SIZE
`define FUNC_SIZE 4
`endif
`ifndef MAX_LENGTH
`define MAX_LENGTH 32
`endif
`ifndef NOP_EXECUTE
`define NOP_EXECUTE 4'd0
`endif
`ifndef ADD_EXECUTE
`define ADD_EXECUTE 4'd1
`endif
`ifndef SUB_EXECUTE
`define SUB_EXECUTE 4'd2
`endif

package decode_issue_stage_pkg;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_ADD  = 4'h1;
    localparam logic [3:0] OPC_SUB  = 4'h2;
    localparam logic [3:0] OPC_ADDI = 4'h3;

`ifdef WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

endpackage

// File: rtl/decode_issue_stage_if.sv
// Execute-side bundle of decode_issue_stage with valid/ready handshake.
// Contents do not depend on WB_BYPASS_EN.
interface decode_issue_stage_if;

    logic                   ex_valid;
    logic                   ex_ready;
    logic [`FUNC_SIZE-1:0]  EXE_CMD;
    logic [`MAX_LENGTH-1:0] valuein1;
    logic [`MAX_LENGTH-1:0] valuein2;
    logic [3:0]             ex_dest;
    logic                   ex_wen;
    logic                   illegal_op;

    modport master (
        output ex_valid, EXE_CMD, valuein1, valuein2,
        output ex_dest, ex_wen, illegal_op,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, EXE_CMD, valuein1, valuein2,
        input  ex_dest, ex_wen, illegal_op,
        output ex_ready
    );

endinterface

// File: rtl/decode_issue_stage_reg_scoreboard.sv
// Per-register pending bits for RAW/WAW hazard detection.
// With WB_BYPASS_EN a same-cycle writeback hides the pending bit.
module reg_scoreboard
    import decode_issue_stage_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  busy_rd
);

    localparam int REG_COUNT = 1 << REG_ADDR_W;

    logic [REG_COUNT-1:0] pend;
    logic [REG_COUNT-1:0] pend_nxt;

    // next pending set: clear first so a same-register set wins
    always_comb begin
        pend_nxt = pend;
        if (clr_en) pend_nxt[clr_addr] = 1'b0;
        if (set_en) pend_nxt[set_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // pending bit register
    always_ff @(posedge clk) begin
        if (rst) pend <= '0;
        else     pend <= pend_nxt;
    end

    function automatic logic busy(input logic [REG_ADDR_W-1:0] a);
        logic hit;
        hit = WB_BYPASS && clr_en && (clr_addr == a);
        return pend[a] && !hit;
    endfunction

    assign busy_rs1 = busy(rs1);
    assign busy_rs2 = busy(rs2);
    assign busy_rd  = busy(rd);

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes fetch words, checks hazards, registers bundle.
// Define WB_BYPASS_EN to forward same-cycle writeback data to sources.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int REG_ADDR_W  = 4,
    parameter int DATA_W      = `MAX_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [INSTR_WIDTH-1:0] if_instr,
    output logic                   if_ready,
    output logic [REG_ADDR_W-1:0]  rf_raddr1,
    output logic [REG_ADDR_W-1:0]  rf_raddr2,
    input  logic [DATA_W-1:0]      rf_rdata1,
    input  logic [DATA_W-1:0]      rf_rdata2,
    input  logic                   wb_valid,
    input  logic [REG_ADDR_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    decode_issue_stage_if.master   ex
);

    logic [3:0]            opc;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;

    assign opc = if_instr[15:12];
    assign rd  = if_instr[11:8];
    assign rs1 = if_instr[7:4];
    assign rs2 = if_instr[3:0];

    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    logic [`FUNC_SIZE-1:0] cmd;
    logic use1;
    logic use2;
    logic writes;
    logic imm_sel;
    logic illegal;

    // opcode decode
    always_comb begin
        cmd     = `NOP_EXECUTE;
        use1    = 1'b0;
        use2    = 1'b0;
        writes  = 1'b0;
        imm_sel = 1'b0;
        illegal = 1'b0;
        unique case (opc)
            OPC_NOP: ;
            OPC_ADD: begin
                cmd    = `ADD_EXECUTE;
                use1   = 1'b1;
                use2   = 1'b1;
                writes = 1'b1;
            end
            OPC_SUB: begin
                cmd    = `SUB_EXECUTE;
                use1   = 1'b1;
                use2   = 1'b1;
                writes = 1'b1;
            end
            OPC_ADDI: begin
                cmd     = `ADD_EXECUTE;
                use1    = 1'b1;
                writes  = 1'b1;
                imm_sel = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    logic wen;
    assign wen = writes && (rd != '0);

    logic hit1;
    logic hit2;
    assign hit1 = WB_BYPASS && wb_valid && (wb_addr == rs1);
    assign hit2 = WB_BYPASS && wb_valid && (wb_addr == rs2);

    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    assign rd1 = (rs1 == '0) ? '0 : (hit1 ? wb_data : rf_rdata1);
    assign rd2 = (rs2 == '0) ? '0 : (hit2 ? wb_data : rf_rdata2);
    assign op1 = use1 ? rd1 : '0;
    assign op2 = imm_sel ? DATA_W'(rs2) : (use2 ? rd2 : '0);

    logic busy_rs1;
    logic busy_rs2;
    logic busy_rd;
    logic hazard;
    logic accept;
    logic ex_valid_q;

    assign hazard = (use1 && busy_rs1)
                 || (use2 && busy_rs2)
                 || (wen && busy_rd);
    assign if_ready = !rst && !hazard
                   && (!ex_valid_q || ex.ex_ready);
    assign accept = if_valid && if_ready;

    reg_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (accept && wen),
        .set_addr (rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_rd  (busy_rd)
    );

    logic [`FUNC_SIZE-1:0] cmd_q;
    logic [DATA_W-1:0]     v1_q;
    logic [DATA_W-1:0]     v2_q;
    logic [3:0]            dest_q;
    logic                  wen_q;

    // output bundle register: load on accept, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            cmd_q      <= `NOP_EXECUTE;
            v1_q       <= '0;
            v2_q       <= '0;
            dest_q     <= '0;
            wen_q      <= 1'b0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            cmd_q      <= cmd;
            v1_q       <= op1;
            v2_q       <= op2;
            dest_q     <= 4'(rd);
            wen_q      <= wen;
        end else if (ex.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign ex.ex_valid   = ex_valid_q;
    assign ex.EXE_CMD    = cmd_q;
    assign ex.valuein1   = v1_q;
    assign ex.valuein2   = v2_q;
    assign ex.ex_dest    = dest_q;
    assign ex.ex_wen     = wen_q;
    assign ex.illegal_op = accept && illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed vectors, queued expectations.
// Build with WB_BYPASS_EN to check the bypass timing variant.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        if_ready;
    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    decode_issue_stage_if exi ();

    decode_issue_stage dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_ready  (if_ready),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .ex        (exi.master)
    );

    always #5 clk = ~clk;

    logic [31:0] rf [16];

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    // register file model written by writeback
    always @(posedge clk) begin
        if (wb_valid && wb_addr != 4'd0) rf[wb_addr] <= wb_data;
    end

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  dest;
        logic        wen;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [3:0] C_NOP = 4'd0;
    localparam logic [3:0] C_ADD = 4'd1;
    localparam logic [3:0] C_SUB = 4'd2;

    task automatic chk(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // monitor: every handshaked bundle is compared with the queue head
    always @(negedge clk) begin
        if (!rst && exi.ex_valid && exi.ex_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_bundle", 64'(exi.EXE_CMD), 64'hFFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("EXE_CMD",  64'(exi.EXE_CMD),  64'(e.cmd));
                chk("valuein1", 64'(exi.valuein1), 64'(e.v1));
                chk("valuein2", 64'(exi.valuein2), 64'(e.v2));
                chk("ex_dest",  64'(exi.ex_dest),  64'(e.dest));
                chk("ex_wen",   64'(exi.ex_wen),   64'(e.wen));
            end
        end
    end

    function automatic exp_t mk(input logic [3:0] c,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                input logic [3:0] d,
                                input logic w);
        exp_t e;
        e.cmd = c; e.v1 = a; e.v2 = b; e.dest = d; e.wen = w;
        return e;
    endfunction

    task automatic issue(input logic [15:0] ins, input exp_t e,
                         input bit ill, input bit push);
        int n;
        if (push) q.push_back(e);
        if_valid = 1'b1;
        if_instr = ins;
        n = 0;
        @(negedge clk);
        while (!if_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", 64'(if_ready), 64'd1);
        chk("illegal_op", 64'(exi.illegal_op), 64'(ill));
        @(posedge clk);
        #1;
        if_valid = 1'b0;
    endtask

    task automatic hazard_issue(input logic [15:0] ins, input exp_t e,
                                input logic [3:0] wa,
                                input logic [31:0] wd);
        q.push_back(e);
        if_valid = 1'b1;
        if_instr = ins;
        repeat (2) begin
            @(negedge clk);
            chk("stall_ready", 64'(if_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        wb_valid = 1'b1;
        wb_addr  = wa;
        wb_data  = wd;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        chk("wb_cycle_ready", 64'(if_ready), 64'd1);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        if_valid = 1'b0;
`else
        chk("wb_cycle_ready", 64'(if_ready), 64'd0);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        @(negedge clk);
        chk("post_wb_ready", 64'(if_ready), 64'd1);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
`endif
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ex_valid", 64'(exi.ex_valid), 64'd0);
        chk("rst_cmd",      64'(exi.EXE_CMD),  64'(C_NOP));
        chk("rst_v1",       64'(exi.valuein1), 64'd0);
        chk("rst_v2",       64'(exi.valuein2), 64'd0);
        chk("rst_dest",     64'(exi.ex_dest),  64'd0);
        chk("rst_wen",      64'(exi.ex_wen),   64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        rf[2] = 32'd5;
        rf[3] = 32'd7;
        rf[4] = 32'h44;
        rst = 1'b1;
        if_valid = 1'b1;
        if_instr = 16'h1123;
        wb_valid = 1'b0;
        wb_addr = 4'd0;
        wb_data = 32'd0;
        exi.ex_ready = 1'b1;

        @(negedge clk);
        chk("ready_in_reset", 64'(if_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;

        // ADD r1,r2,r3
        issue(16'h1123, mk(C_ADD, 5, 7, 1, 1), 0, 1);
        // SUB r4,r1,r2 waits for writeback of r1
        hazard_issue(16'h2412, mk(C_SUB, 12, 5, 4, 1), 4'd1, 32'd12);
        // ADDI r5,r0,0xF
        issue(16'h350F, mk(C_ADD, 0, 15, 5, 1), 0, 1);
        // NOP
        issue(16'h0000, mk(C_NOP, 0, 0, 0, 0), 0, 1);
        // illegal opcode 0x9
        issue(16'h9000, mk(C_NOP, 0, 0, 0, 0), 1, 1);
        @(negedge clk);
        chk("illegal_once", 64'(exi.illegal_op), 64'd0);
        @(posedge clk);
        #1;

        // ADD r6,r2,r3 with stale writeback to r6 in the accept cycle
        wb_valid = 1'b1;
        wb_addr  = 4'd6;
        wb_data  = 32'd99;
        issue(16'h1623, mk(C_ADD, 5, 7, 6, 1), 0, 1);
        wb_valid = 1'b0;
        exi.ex_ready = 1'b0;
        q.push_back(mk(C_ADD, 0, 3, 7, 1));
        if_valid = 1'b1;
        if_instr = 16'h3703;
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", 64'(exi.ex_valid), 64'd1);
            chk("hold_cmd",   64'(exi.EXE_CMD),  64'(C_ADD));
            chk("hold_v1",    64'(exi.valuein1), 64'd5);
            chk("hold_v2",    64'(exi.valuein2), 64'd7);
            chk("hold_dest",  64'(exi.ex_dest),  64'd6);
            chk("hold_ready", 64'(if_ready),     64'd0);
            @(posedge clk);
            #1;
        end
        exi.ex_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", 64'(if_ready), 64'd1);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        @(negedge clk);
        chk("queued_issue", 64'(exi.ex_valid), 64'd1);
        @(posedge clk);
        #1;

        // ADD r8,r6,r0 must stall: r6 stayed pending
        hazard_issue(16'h1860, mk(C_ADD, 20, 0, 8, 1), 4'd6, 32'd20);

        // ADD r1 held under backpressure, SUB r9,r1,r4 stalls, then reset
        issue(16'h1123, mk(C_ADD, 5, 7, 1, 1), 0, 0);
        exi.ex_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = 16'h2914;
        @(negedge clk);
        chk("pre_rst_stall", 64'(if_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_in_rst2", 64'(if_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exi.ex_ready = 1'b1;
        q.push_back(mk(C_SUB, 12, 32'h44, 9, 1));
        @(negedge clk);
        chk_reset_outputs();
        chk("post_rst_ready", 64'(if_ready), 64'd1);
        @(posedge clk);
        #1;
        if_valid = 1'b0;

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Instruction decode/issue stage that produces the execute-command and operand bundle consumed by the ALU execute stage.
- Input side: instruction words from fetch. Output side: `FUNC_SIZE command plus two `MAX_LENGTH operands.
- A per-register scoreboard blocks RAW and WAW hazards until writeback.
- Output bundle is registered, with valid/ready handshakes on both sides.

Parameters:
- INSTR_WIDTH, 16, instruction word width. Format: opcode[15:12], rd[11:8], rs1[7:4], rs2_or_imm[3:0].
- REG_ADDR_W, 4, register index width (16 registers; r0 reads zero and is never written).
- DATA_W, `MAX_LENGTH, operand width.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch has an instruction.
- if_instr  in  INSTR_WIDTH  instruction word.
- if_ready  out  1  stage accepts if_instr this cycle.
- rf_raddr1  out  REG_ADDR_W  register-file read address, equal to rs1 (combinational).
- rf_raddr2  out  REG_ADDR_W  register-file read address, equal to rs2 (combinational).
- rf_rdata1  in  DATA_W  asynchronous read data.
- rf_rdata2  in  DATA_W  asynchronous read data.
- wb_valid  in  1  writeback completes this cycle.
- wb_addr  in  REG_ADDR_W  writeback register.
- wb_data  in  DATA_W  writeback value.
- ex_valid  out  1  output bundle valid.
- ex_ready  in  1  execute stage accepts the bundle.
- EXE_CMD  out  `FUNC_SIZE  execute command.
- valuein1  out  DATA_W  operand 1.
- valuein2  out  DATA_W  operand 2.
- ex_dest  out  REG_ADDR_W  destination register.
- ex_wen  out  1  result must be written back.
- illegal_op  out  1  one-cycle pulse when an illegal opcode is accepted.

Behaviour:
- Opcodes:
  - 0x0 NOP: EXE_CMD=`NOP_EXECUTE, ex_wen=0.
  - 0x1 ADD: `ADD_EXECUTE, v1=R[rs1], v2=R[rs2].
  - 0x2 SUB: `SUB_EXECUTE, same operands as ADD.
  - 0x3 ADDI: `ADD_EXECUTE, v2=imm4 zero-extended to DATA_W.
  - 0x4..0xF: illegal. Issued as NOP with ex_wen=0; illegal_op=1 on the accept cycle.
- Register reads: reading r0 yields 0 regardless of rf_rdata. ex_wen=0 whenever rd=0.
- Reads used:
  - rs1 used by ADD/SUB/ADDI.
  - rs2 used by ADD/SUB only.
- Scoreboard: REG_COUNT bits, r0 bit tied 0.
  - A bit is set when an instruction with ex_wen=1 is accepted; it marks rd pending.
  - A bit is cleared when wb_valid=1 for wb_addr.
  - Set and clear on the same register in the same cycle: set wins.
- Hazard (stall) when either holds:
  - Any used source register is pending.
  - rd (when ex_wen=1) is pending (WAW).
- Same-cycle writeback to a pending source still stalls (register file updates on that edge); the instruction issues next cycle.
- Handshakes:
  - if_ready = !hazard && (!ex_valid || ex_ready). if_ready depends on if_instr but never on if_valid.
  - Accept = if_valid && if_ready. The output register loads on accept with latency 1: ex_valid=1 on the next cycle.
  - When ex_valid && !ex_ready, all outputs hold stable.
  - When ex_ready=1 and nothing is accepted, ex_valid drops to 0 next cycle.
  - Back-to-back issue at one instruction per cycle when there are no hazards.
- Arithmetic: no arithmetic is done here. Immediate zero-extension only.
- Reset (synchronous):
  - ex_valid=0, EXE_CMD=`NOP_EXECUTE, valuein1=valuein2=0, ex_dest=0, ex_wen=0, illegal_op=0, scoreboard all 0.
  - if_ready during rst: 0.
  - Reset mid-stall discards the bundle and pending bits. Stale wb_valid after reset clears an already-clear bit, which is harmless.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - A source equal to wb_addr with wb_valid=1 (and nonzero) takes wb_data instead of rf_rdata.
  - A pending bit cleared by a same-cycle writeback does not cause a stall for that source.
  - WAW check is unchanged, except a same-cycle clear of rd also removes that stall.
- Undefined: behaviour exactly as above (stall one cycle past writeback).

Decomposition:
- Shared package/header `defines.v` holds:
  - `FUNC_SIZE, `MAX_LENGTH, and the command encodings `NOP_EXECUTE/`ADD_EXECUTE/`SUB_EXECUTE.
  - New opcode constants OPC_NOP/OPC_ADD/OPC_SUB/OPC_ADDI.
- Sub-module: reg_scoreboard. It owns set/clear/priority logic and pending-bit query outputs for rs1/rs2/rd.

Test Plan:
- Reset, then ADD r1,r2,r3 with R2=5, R3=7, ex_ready=1 -> next cycle ex_valid=1, EXE_CMD=ADD, v1=5, v2=7, ex_dest=1, ex_wen=1; bit1 set.
- SUB r4,r1,r2 issued immediately after ADD r1 -> if_ready=0 until wb_valid(addr=1). Without bypass, issue occurs the cycle after wb. With WB_BYPASS_EN, issue occurs in the wb cycle and v1=wb_data (e.g. 12).
- ADDI r5,r0,0xF -> v1=0, v2=15. Then opcode 0x9 -> EXE_CMD=NOP, ex_wen=0, illegal_op pulses once.
- ex_ready held 0 for 3 cycles with valid bundle -> all outputs stable, if_ready=0; ex_ready=1 -> next queued instruction issues the following cycle.
- wb_valid(addr=6) in the same cycle as accepting ADD r6,... -> bit6 remains set. A later read of r6 stalls.
- rst asserted while stalled with bits 1,4 set -> next cycle ex_valid=0, all outputs 0/NOP, scoreboard clear, held instruction issues without stall after rst drops.
